prga: RTL

PRGA -- requirements
Module: prga

---
 rtl/arc4_pkg.sv | 23 ++
 rtl/prga.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 keystream blocks: fixed bus widths,
// the printable-ASCII window and the PRGA state encoding.
package arc4_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] ASCII_MIN = 8'h20;
    localparam logic [DATA_W-1:0] ASCII_MAX = 8'h7E;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_LEN = 4'd1,
        WR_LEN = 4'd2,
        RD_SI  = 4'd3,
        RD_SJ  = 4'd4,
        WR_SI  = 4'd5,
        WR_SJ  = 4'd6,
        RD_PAD = 4'd7,
        WR_PT  = 4'd8
    } prga_state_e;

endpackage : arc4_pkg

// File: rtl/prga.sv
// ARC4 pseudo-random generation: walks the S array left by key scheduling,
// swaps s[i]/s[j] per byte and XORs the pad into the length-prefixed
// ciphertext, writing the length-prefixed plaintext.
//
// Optional feature: define PRGA_ASCII_CHECK_EN to make pt_valid report
// whether every decrypted byte (excluding the length byte) is printable.
// Without it pt_valid is tied high.
//
// Handshake: en is a start request that is only accepted on an edge where
// rdy=1; rdy drops in the following cycle and rises again once the last
// plaintext byte has been written. en while rdy=0 has no effect.
//
// All memories have a one-cycle read latency, so every address is decoded
// combinationally from the current state and the returned data is consumed
// in the next state. The read data is used directly where a state needs it
// in the same cycle (j update, swap writes, plaintext write).
module prga
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_wrdata,
    output logic              pt_wren,
    output logic              pt_valid
);

    prga_state_e       state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] si_q, si_d;
    logic [DATA_W-1:0] sj_q, sj_d;
    logic [DATA_W-1:0] pt_byte;

    // pad byte arrives on s_rddata and ciphertext byte on ct_rddata in WR_PT
    assign pt_byte = s_rddata ^ ct_rddata;

    // next-state, index updates and memory port decode
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_d = RD_LEN;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            RD_LEN: begin
                ct_addr = '0;
                state_d = WR_LEN;
            end
            WR_LEN: begin
                len_d     = ct_rddata;
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                k_d       = 8'd1;
                state_d   = (ct_rddata == '0) ? IDLE : RD_SI;
            end
            RD_SI: begin
                i_d     = i_q + 8'd1;
                s_addr  = i_q + 8'd1;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                state_d = WR_SI;
            end
            WR_SI: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = WR_SJ;
            end
            WR_SJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = RD_PAD;
            end
            RD_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
                state_d = WR_PT;
            end
            WR_PT: begin
                pt_addr   = k_q;
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = RD_SI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and index registers; reset returns to an idle, fresh pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

`ifdef PRGA_ASCII_CHECK_EN
    logic valid_q, valid_d;

    // sticky non-printable flag, re-armed on every accepted start
    always_comb begin
        valid_d = valid_q;
        if (state_q == IDLE && en) begin
            valid_d = 1'b1;
        end else if (state_q == WR_PT &&
                     (pt_byte < ASCII_MIN || pt_byte > ASCII_MAX)) begin
            valid_d = 1'b0;
        end
    end

    // printable-status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign pt_valid = valid_q;
`else
    assign pt_valid = 1'b1;
`endif

endmodule : prga
